alarm_snooze_ctrl: RTL



---
 rtl/alarm_pkg.sv | 27 ++
 rtl/beep_pattern_gen.sv | 51 +++++
 rtl/alarm_snooze_ctrl.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/alarm_pkg.sv
// Shared types, default timing constants and a counter-width helper for the
// alarm snooze controller.
package alarm_pkg;

  // Controller states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RING   = 2'd1,
    SNOOZE = 2'd2,
    QUIET  = 2'd3
  } alarm_state_e;

  // Default timing, all in 1 Hz ticks
  localparam int unsigned DEF_BEEP_ON     = 2;
  localparam int unsigned DEF_BEEP_OFF    = 1;
  localparam int unsigned DEF_RING_MAX    = 60;
  localparam int unsigned DEF_SNOOZE_SEC  = 300;
  localparam int unsigned DEF_HOLDOFF_SEC = 60;
  localparam int unsigned DEF_MAX_SNOOZE  = 3;
  localparam int unsigned DEF_ESC_STEP    = 15;

  // Bits needed to hold values 0..max_val (never less than one bit)
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/beep_pattern_gen.sv
// Beep pattern generator: buzzer high for BEEP_ON ticks, low for BEEP_OFF
// ticks, repeating, always starting high on restart. The output is registered
// and forced low whenever the generator is neither restarted nor enabled.
module beep_pattern_gen
  import alarm_pkg::*;
#(
  parameter int unsigned BEEP_ON  = DEF_BEEP_ON,
  parameter int unsigned BEEP_OFF = DEF_BEEP_OFF
) (
  input  logic clk_1s,
  input  logic reset,
  input  logic restart,
  input  logic enable,
  output logic buzzer
);

  localparam int unsigned PERIOD = BEEP_ON + BEEP_OFF;
  localparam int unsigned PH_W   = cnt_width(PERIOD);

  logic [PH_W-1:0] r_phase;
  logic [PH_W-1:0] w_phase_nxt;
  logic            r_buzzer;

  // Phase index of the next tick, wrapping at the end of the period
  always_comb begin
    w_phase_nxt = r_phase + PH_W'(1);
    if (r_phase == PH_W'(PERIOD - 1)) begin
      w_phase_nxt = '0;
    end
  end

  // Phase counter and registered buzzer drive
  always_ff @(posedge clk_1s or posedge reset) begin
    if (reset) begin
      r_phase  <= '0;
      r_buzzer <= 1'b0;
    end else if (restart) begin
      r_phase  <= '0;
      r_buzzer <= 1'b1;
    end else if (enable) begin
      r_phase  <= w_phase_nxt;
      r_buzzer <= (w_phase_nxt < PH_W'(BEEP_ON));
    end else begin
      r_phase  <= '0;
      r_buzzer <= 1'b0;
    end
  end

  assign buzzer = r_buzzer;

endmodule

// File: rtl/alarm_snooze_ctrl.sv
// Alarm snooze controller: turns the clock core's Alarm level into a beeping
// buzzer, handles snooze/stop buttons, ring timeout and snooze re-ring, and
// holds stop_al back to the core so the minute-long match cannot re-trigger.
// Optional volume escalation is built when ALARM_ESCALATE_EN is defined;
// otherwise buzz_level is full scale while ringing.
module alarm_snooze_ctrl
  import alarm_pkg::*;
#(
  parameter int unsigned BEEP_ON     = DEF_BEEP_ON,
  parameter int unsigned BEEP_OFF    = DEF_BEEP_OFF,
  parameter int unsigned RING_MAX    = DEF_RING_MAX,
  parameter int unsigned SNOOZE_SEC  = DEF_SNOOZE_SEC,
  parameter int unsigned HOLDOFF_SEC = DEF_HOLDOFF_SEC,
  parameter int unsigned MAX_SNOOZE  = DEF_MAX_SNOOZE
`ifdef ALARM_ESCALATE_EN
  ,
  parameter int unsigned ESC_STEP    = DEF_ESC_STEP
`endif
) (
  input  logic       clk_1s,
  input  logic       reset,
  input  logic       alarm_in,
  input  logic       snooze_btn,
  input  logic       stop_btn,
  output logic       buzzer,
  output logic [1:0] buzz_level,
  output logic       stop_al,
  output logic       ringing,
  output logic       snoozing,
  output logic [2:0] snooze_count
);

  localparam int unsigned RING_W = cnt_width(RING_MAX);
  localparam int unsigned SNZ_W  = cnt_width(SNOOZE_SEC);
  localparam int unsigned HOLD_W = cnt_width(HOLDOFF_SEC);
  localparam int unsigned CNT_W  = 3;

  alarm_state_e      r_state;
  alarm_state_e      w_state_nxt;

  logic              r_alarm_q;
  logic              r_snooze_q;
  logic              r_stop_q;

  logic [RING_W-1:0] r_ring_t;
  logic [RING_W-1:0] w_ring_t_nxt;
  logic [SNZ_W-1:0]  r_snz_t;
  logic [SNZ_W-1:0]  w_snz_t_nxt;
  logic [HOLD_W-1:0] r_hold_t;
  logic [HOLD_W-1:0] w_hold_t_nxt;
  logic [CNT_W-1:0]  r_snooze_count;
  logic [CNT_W-1:0]  w_snooze_count_nxt;

  logic              r_stop_al;
  logic              r_ringing;
  logic              r_snoozing;
  logic [1:0]        r_buzz_level;

  logic              w_alarm_rise;
  logic              w_snooze_rise;
  logic              w_stop_rise;
  logic              w_ring_done;
  logic              w_can_snooze;
  logic              w_snz_done;
  logic              w_hold_done;
  logic              w_beep_restart;
  logic              w_beep_enable;
  logic              w_buzzer;

  assign w_alarm_rise  = alarm_in   & ~r_alarm_q;
  assign w_snooze_rise = snooze_btn & ~r_snooze_q;
  assign w_stop_rise   = stop_btn   & ~r_stop_q;
  assign w_ring_done   = (r_ring_t == RING_W'(RING_MAX - 1));
  assign w_can_snooze  = (r_snooze_count < CNT_W'(MAX_SNOOZE));
  assign w_snz_done    = (r_snz_t == '0);
  assign w_hold_done   = (r_hold_t == HOLD_W'(HOLDOFF_SEC - 1));

  // Beep pattern restarts on every entry to RING and runs while staying there
  assign w_beep_restart = (w_state_nxt == RING) && (r_state != RING);
  assign w_beep_enable  = (w_state_nxt == RING) && (r_state == RING);

  // Registered copies of the inputs for rising-edge detection
  always_ff @(posedge clk_1s or posedge reset) begin
    if (reset) begin
      r_alarm_q  <= 1'b0;
      r_snooze_q <= 1'b0;
      r_stop_q   <= 1'b0;
    end else begin
      r_alarm_q  <= alarm_in;
      r_snooze_q <= snooze_btn;
      r_stop_q   <= stop_btn;
    end
  end

  // Next state and next counter values; stop beats snooze and timeout
  always_comb begin
    w_state_nxt        = r_state;
    w_ring_t_nxt       = r_ring_t;
    w_snz_t_nxt        = r_snz_t;
    w_hold_t_nxt       = r_hold_t;
    w_snooze_count_nxt = r_snooze_count;
    case (r_state)
      IDLE: begin
        if (w_alarm_rise) begin
          w_state_nxt  = RING;
          w_ring_t_nxt = '0;
        end
      end
      RING: begin
        if (w_stop_rise) begin
          w_state_nxt  = QUIET;
          w_hold_t_nxt = '0;
        end else if (w_can_snooze && (w_snooze_rise || w_ring_done)) begin
          w_state_nxt        = SNOOZE;
          w_snooze_count_nxt = r_snooze_count + CNT_W'(1);
          w_snz_t_nxt        = SNZ_W'(SNOOZE_SEC - 1);
          w_hold_t_nxt       = '0;
        end else if (w_ring_done) begin
          w_state_nxt  = QUIET;
          w_hold_t_nxt = '0;
        end else begin
          w_ring_t_nxt = r_ring_t + RING_W'(1);
        end
      end
      SNOOZE: begin
        if (w_stop_rise) begin
          w_state_nxt  = QUIET;
          w_hold_t_nxt = '0;
        end else if (w_snz_done) begin
          w_state_nxt  = RING;
          w_ring_t_nxt = '0;
        end else begin
          w_snz_t_nxt = r_snz_t - SNZ_W'(1);
        end
      end
      QUIET: begin
        if (w_hold_done) begin
          w_state_nxt        = IDLE;
          w_snooze_count_nxt = '0;
        end else begin
          w_hold_t_nxt = r_hold_t + HOLD_W'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State, counters and state-derived outputs, all updated on the same edge
  always_ff @(posedge clk_1s or posedge reset) begin
    if (reset) begin
      r_state        <= IDLE;
      r_ring_t       <= '0;
      r_snz_t        <= '0;
      r_hold_t       <= '0;
      r_snooze_count <= '0;
      r_stop_al      <= 1'b0;
      r_ringing      <= 1'b0;
      r_snoozing     <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_ring_t       <= w_ring_t_nxt;
      r_snz_t        <= w_snz_t_nxt;
      r_hold_t       <= w_hold_t_nxt;
      r_snooze_count <= w_snooze_count_nxt;
      r_stop_al      <= (w_state_nxt == SNOOZE) || (w_state_nxt == QUIET);
      r_ringing      <= (w_state_nxt == RING);
      r_snoozing     <= (w_state_nxt == SNOOZE);
    end
  end

`ifdef ALARM_ESCALATE_EN
  localparam int unsigned ESC_W = cnt_width(ESC_STEP);

  logic [ESC_W-1:0] r_esc_t;

  // Volume steps up every ESC_STEP ring ticks, held across snooze, reset on a
  // fresh alarm event and cleared once the event ends
  always_ff @(posedge clk_1s or posedge reset) begin
    if (reset) begin
      r_esc_t      <= '0;
      r_buzz_level <= 2'b00;
    end else if (w_beep_restart) begin
      r_esc_t <= '0;
      if (r_state == IDLE) begin
        r_buzz_level <= 2'b00;
      end
    end else if (w_beep_enable) begin
      if (r_esc_t == ESC_W'(ESC_STEP - 1)) begin
        r_esc_t <= '0;
        if (r_buzz_level != 2'b11) begin
          r_buzz_level <= r_buzz_level + 2'd1;
        end
      end else begin
        r_esc_t <= r_esc_t + ESC_W'(1);
      end
    end else if (w_state_nxt != SNOOZE) begin
      r_esc_t      <= '0;
      r_buzz_level <= 2'b00;
    end
  end
`else
  // Full volume whenever ringing
  always_ff @(posedge clk_1s or posedge reset) begin
    if (reset) begin
      r_buzz_level <= 2'b00;
    end else begin
      r_buzz_level <= (w_state_nxt == RING) ? 2'b11 : 2'b00;
    end
  end
`endif

  beep_pattern_gen #(
    .BEEP_ON  (BEEP_ON),
    .BEEP_OFF (BEEP_OFF)
  ) u_beep (
    .clk_1s  (clk_1s),
    .reset   (reset),
    .restart (w_beep_restart),
    .enable  (w_beep_enable),
    .buzzer  (w_buzzer)
  );

  assign buzzer       = w_buzzer;
  assign buzz_level   = r_buzz_level;
  assign stop_al      = r_stop_al;
  assign ringing      = r_ringing;
  assign snoozing     = r_snoozing;
  assign snooze_count = r_snooze_count;

endmodule
